// File: rtl/cycle_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cycle_sequencer_pkg
//
// Shared definitions for the timing / instruction-cycle sequencer:
//   phase_e    - encoding of the Phase output (fetch, decode, execute,
//                interrupt)
//   SC_DECODE  - the sequence-counter slot in which the opcode is decoded;
//                the increment out of this slot latches D and I, and the
//                CLR_SC issued in this slot ends an interrupt cycle.
// ---------------------------------------------------------------------------
package cycle_sequencer_pkg;

    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_DECODE = 2'd1,
        PH_EXEC   = 2'd2,
        PH_INT    = 2'd3
    } phase_e;

    localparam int unsigned SC_DECODE = 2;

endpackage

// File: rtl/cycle_sequencer_onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
//
// Binary-to-one-hot decoder with an enable. When en is low the output is
// all zeros. Used by the sequencer both for the timing lines T (enabled by
// the run flag) and for the opcode decode lines D.
//
// Ports:
//   sel    in  WIDTH       binary select
//   en     in  1           output enable
//   onehot out 2**WIDTH    onehot[sel] = en, all other bits zero
// ---------------------------------------------------------------------------
module onehot_decoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]        sel,
    input  logic                    en,
    output logic [(1<<WIDTH)-1:0]   onehot
);

    // Single set bit selected by sel; nothing set while disabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// ---------------------------------------------------------------------------
// cycle_sequencer
//
// Timing and instruction-cycle sequencer for the control unit. Holds the
// sequence counter SC, the run flag S, the interrupt-cycle flag R, the
// latched indirect bit I, the latched opcode decode D and a counter of
// retired instructions. T and Phase are decoded combinationally from the
// registered SC/S/R; every other output comes straight from a flop.
//
// Ports:
//   Clk         in   1          clock, rising edge
//   Reset       in   1          synchronous active-high reset
//   Start       in   1          set the run flag S
//   Halt        in   1          clear S and force SC to 0 (beats Start)
//   CLR_SC      in   1          clear SC (end of instruction)
//   INR_SC      in   1          advance SC
//   Stall       in   1          memory wait, freezes SC
//   Opcode      in   OPC_WIDTH  opcode field of IR
//   I_bit       in   1          indirect bit of IR
//   IEN/FGI/FGO in   1          interrupt enable and device flags
//   T           out  NUM_T      one-hot T[SC], zero while S=0
//   D           out  NUM_D      one-hot latched opcode
//   I           out  1          latched indirect bit
//   R           out  1          interrupt-cycle flag
//   S           out  1          run flag
//   SC          out  SC_WIDTH   sequence counter
//   Phase       out  2          FETCH/DECODE/EXECUTE/INTERRUPT
//   Wrap_err    out  1          one-cycle pulse after SC wraps
//   Instr_count out  CNT_WIDTH  retired-instruction count (wrapping)
// ---------------------------------------------------------------------------
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int SC_WIDTH  = 4,
    parameter int OPC_WIDTH = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic                        Halt,
    input  logic                        CLR_SC,
    input  logic                        INR_SC,
    input  logic                        Stall,
    input  logic [OPC_WIDTH-1:0]        Opcode,
    input  logic                        I_bit,
    input  logic                        IEN,
    input  logic                        FGI,
    input  logic                        FGO,
    output logic [(1<<SC_WIDTH)-1:0]    T,
    output logic [(1<<OPC_WIDTH)-1:0]   D,
    output logic                        I,
    output logic                        R,
    output logic                        S,
    output logic [SC_WIDTH-1:0]         SC,
    output logic [1:0]                  Phase,
    output logic                        Wrap_err,
    output logic [CNT_WIDTH-1:0]        Instr_count
);

    localparam int NUM_D = 1 << OPC_WIDTH;

    localparam logic [SC_WIDTH-1:0] SC_MAX    = '1;
    localparam logic [SC_WIDTH-1:0] SC_DEC    = SC_WIDTH'(SC_DECODE);
    localparam logic [SC_WIDTH-1:0] SC_ONE    = SC_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SC_WIDTH-1:0]  sc_q, sc_d;
    logic                 s_q, s_d;
    logic                 r_q, r_d;
    logic                 i_q, i_d;
    logic [NUM_D-1:0]     d_q, d_d;
    logic                 wrap_q, wrap_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 running;
    logic                 inc_edge;
    logic                 clr_edge;
    logic                 decode_latch;
    logic                 irq_set;
    logic                 irq_clr;
    logic [NUM_D-1:0]     opc_onehot;
    phase_e               phase;

    // Timing lines: only meaningful while the sequencer is running.
    onehot_decoder #(
        .WIDTH (SC_WIDTH)
    ) u_t_dec (
        .sel    (sc_q),
        .en     (s_q),
        .onehot (T)
    );

    // Opcode decode; the result is only captured into d_q in the decode slot.
    onehot_decoder #(
        .WIDTH (OPC_WIDTH)
    ) u_d_dec (
        .sel    (Opcode),
        .en     (1'b1),
        .onehot (opc_onehot)
    );

    // Edge qualifiers. CLR_SC, Stall and INR_SC only matter while S is set
    // and no Halt is pending, with CLR_SC ranking above Stall above INR_SC.
    always_comb begin
        running      = s_q && !Halt;
        clr_edge     = running && CLR_SC;
        inc_edge     = running && !CLR_SC && !Stall && INR_SC;
        decode_latch = inc_edge && (sc_q == SC_DEC) && !r_q;
        irq_set      = s_q && !r_q && (sc_q > SC_DEC) && IEN && (FGI || FGO);
        irq_clr      = r_q && (sc_q == SC_DEC) && CLR_SC;
    end

    // Next-state computation for all sequencer registers. Halt clears SC
    // even when the sequencer is already stopped; the natural SC+1 overflow
    // provides the wrap to zero.
    always_comb begin
        sc_d   = sc_q;
        s_d    = s_q;
        r_d    = r_q;
        i_d    = i_q;
        d_d    = d_q;
        wrap_d = 1'b0;
        cnt_d  = cnt_q;

        if (Halt) begin
            s_d = 1'b0;
        end else if (Start) begin
            s_d = 1'b1;
        end

        if (Halt) begin
            sc_d = '0;
        end else if (clr_edge) begin
            sc_d = '0;
        end else if (inc_edge) begin
            sc_d   = sc_q + SC_ONE;
            wrap_d = (sc_q == SC_MAX);
        end

        if (decode_latch) begin
            d_d = opc_onehot;
            i_d = I_bit;
        end

        if (irq_clr) begin
            r_d = 1'b0;
        end else if (irq_set) begin
            r_d = 1'b1;
        end

        if (clr_edge && !r_q) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Phase is derived from registered state only, so it is glitch-free
    // with respect to the inputs. The interrupt cycle overrides the SC slot.
    always_comb begin
        if (r_q) begin
            phase = PH_INT;
        end else if (sc_q < SC_DEC) begin
            phase = PH_FETCH;
        end else if (sc_q == SC_DEC) begin
            phase = PH_DECODE;
        end else begin
            phase = PH_EXEC;
        end
    end

    // State registers; Reset beats every other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sc_q   <= '0;
            s_q    <= 1'b0;
            r_q    <= 1'b0;
            i_q    <= 1'b0;
            d_q    <= '0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sc_q   <= sc_d;
            s_q    <= s_d;
            r_q    <= r_d;
            i_q    <= i_d;
            d_q    <= d_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
        end
    end

    assign SC          = sc_q;
    assign S           = s_q;
    assign R           = r_q;
    assign I           = i_q;
    assign D           = d_q;
    assign Wrap_err    = wrap_q;
    assign Instr_count = cnt_q;
    assign Phase       = phase;

endmodule
